// File: rtl/pc_select_unit.sv
// -----------------------------------------------------------------------------
// pc_select_unit
//
// Program-counter register with next-PC source selection and a single-entry
// pending-redirect buffer. A redirect (sel_IN != 00) that arrives while the
// pipeline is stalled is captured and replayed on the first non-stalled edge.
// Only the oldest redirect is kept while stalled.
//
// Parameters
//   WIDTH      : PC / target width in bits (>= 8)
//   RESET_ADDR : PC value loaded on reset
//   INC        : sequential PC increment
//
// Ports
//   Clk        in   1      clock, rising-edge
//   Reset      in   1      synchronous, active-high reset
//   Stall      in   1      hold PC when high
//   sel_IN     in   2      next-PC source: 00 PC_4, 01 jump_JAL, 10 branch, 11 JR
//   jump_JAL   in   WIDTH  jump / JAL target
//   branch     in   WIDTH  taken-branch target
//   JR         in   WIDTH  register-jump target
//   PC         out  WIDTH  current PC (registered)
//   PC_4       out  WIDTH  PC + INC, wraps modulo 2^WIDTH (combinational)
//   pend_valid out  1      a stalled redirect is pending (registered)
//   misaligned out  1      PC[1:0] != 00 (combinational)
// -----------------------------------------------------------------------------
module pc_select_unit #(
    parameter int unsigned           WIDTH      = 32,
    parameter logic [WIDTH-1:0]      RESET_ADDR = '0,
    parameter logic [WIDTH-1:0]      INC        = WIDTH'(4)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic [1:0]       sel_IN,
    input  logic [WIDTH-1:0] jump_JAL,
    input  logic [WIDTH-1:0] branch,
    input  logic [WIDTH-1:0] JR,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_4,
    output logic             pend_valid,
    output logic             misaligned
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend_target;
    logic             r_pend_valid;

    logic [WIDTH-1:0] w_pc_4;
    logic [WIDTH-1:0] w_sel_target;

    // Modulo-2^WIDTH increment: carry out is simply dropped.
    always_comb begin
        w_pc_4 = r_pc + INC;
    end

    always_comb begin
        w_sel_target = w_pc_4;
        unique case (sel_IN)
            2'b00: w_sel_target = w_pc_4;
            2'b01: w_sel_target = jump_JAL;
            2'b10: w_sel_target = branch;
            2'b11: w_sel_target = JR;
            default: w_sel_target = w_pc_4;
        endcase
    end

    // PC and pending-valid carry reset; the pending target does not, since it
    // is never observed while r_pend_valid is low.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc         <= RESET_ADDR;
            r_pend_valid <= 1'b0;
        end else if (Stall) begin
            // First redirect during a stall wins; later ones are dropped.
            if (!r_pend_valid && (sel_IN != 2'b00)) begin
                r_pend_valid <= 1'b1;
            end
        end else if (r_pend_valid) begin
            // Replay the captured redirect; this cycle's sel_IN is ignored.
            r_pc         <= r_pend_target;
            r_pend_valid <= 1'b0;
        end else begin
            r_pc <= w_sel_target;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && Stall && !r_pend_valid && (sel_IN != 2'b00)) begin
            r_pend_target <= w_sel_target;
        end
    end

    assign PC         = r_pc;
    assign PC_4       = w_pc_4;
    assign pend_valid = r_pend_valid;
    assign misaligned = (r_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_select_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_select_unit
//
// Table-driven bench for pc_select_unit (WIDTH=32, RESET_ADDR=0, INC=4), plus
// a hand-written sequence on a WIDTH=16, RESET_ADDR=0x1000 instance.
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_pc_select_unit;

    typedef struct {
        bit          rst;
        bit          stall;
        logic [1:0]  sel;
        logic [31:0] jal;
        logic [31:0] br;
        logic [31:0] jr;
        logic [31:0] e_pc;
        bit          e_pend;
    } vec_t;

    localparam int unsigned NVEC = 23;

    logic        clk;
    logic        rst, stall;
    logic [1:0]  sel;
    logic [31:0] jal, br, jr;
    logic [31:0] pc, pc4;
    logic        pend, mis;

    logic        rst16, stall16;
    logic [1:0]  sel16;
    logic [15:0] jal16, br16, jr16;
    logic [15:0] pc16, pc4_16;
    logic        pend16, mis16;

    int total = 0;
    int bad   = 0;

    vec_t vecs [NVEC];

    pc_select_unit dut (
        .Clk        (clk),
        .Reset      (rst),
        .Stall      (stall),
        .sel_IN     (sel),
        .jump_JAL   (jal),
        .branch     (br),
        .JR         (jr),
        .PC         (pc),
        .PC_4       (pc4),
        .pend_valid (pend),
        .misaligned (mis)
    );

    pc_select_unit #(
        .WIDTH      (16),
        .RESET_ADDR (16'h1000)
    ) dut16 (
        .Clk        (clk),
        .Reset      (rst16),
        .Stall      (stall16),
        .sel_IN     (sel16),
        .jump_JAL   (jal16),
        .branch     (br16),
        .JR         (jr16),
        .PC         (pc16),
        .PC_4       (pc4_16),
        .pend_valid (pend16),
        .misaligned (mis16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit r, input bit s, input logic [1:0] sl,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] epc,
                                input bit ep);
        vec_t v;
        v.rst = r; v.stall = s; v.sel = sl;
        v.jal = a; v.br = b; v.jr = c;
        v.e_pc = epc; v.e_pend = ep;
        return v;
    endfunction

    initial begin
        logic [31:0] epc4;
        logic        emis;

        //            rst stall sel    jal           branch        JR            exp PC        pend
        vecs[0]  = mk(1, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 0);
        vecs[1]  = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 0);
        vecs[2]  = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0000_0008, 0);
        vecs[3]  = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0000_000C, 0);
        vecs[4]  = mk(0, 0, 2'b11, 32'h0,        32'h0,        32'h100,      32'h0000_0100, 0);
        vecs[5]  = mk(0, 0, 2'b10, 32'h0,        32'h200,      32'h0,        32'h0000_0200, 0);
        vecs[6]  = mk(0, 0, 2'b11, 32'h0,        32'h0,        32'h3C,       32'h0000_003C, 0);
        vecs[7]  = mk(0, 0, 2'b11, 32'h0,        32'h0,        32'h40,       32'h0000_0040, 0);
        vecs[8]  = mk(0, 1, 2'b01, 32'h80,       32'h0,        32'h0,        32'h0000_0040, 1);
        vecs[9]  = mk(0, 1, 2'b10, 32'h0,        32'h90,       32'h0,        32'h0000_0040, 1);
        vecs[10] = mk(0, 1, 2'b00, 32'h44,       32'h0,        32'h0,        32'h0000_0040, 1);
        vecs[11] = mk(0, 0, 2'b11, 32'h0,        32'h0,        32'h300,      32'h0000_0080, 0);
        vecs[12] = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0000_0084, 0);
        vecs[13] = mk(0, 0, 2'b11, 32'h0,        32'h0,        32'hFFFF_FFFC,32'hFFFF_FFFC, 0);
        vecs[14] = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 0);
        vecs[15] = mk(0, 0, 2'b11, 32'h0,        32'h0,        32'h102,      32'h0000_0102, 0);
        vecs[16] = mk(0, 0, 2'b01, 32'h40,       32'h0,        32'h0,        32'h0000_0040, 0);
        vecs[17] = mk(0, 1, 2'b01, 32'h80,       32'h0,        32'h0,        32'h0000_0040, 1);
        vecs[18] = mk(1, 1, 2'b01, 32'h80,       32'h0,        32'h0,        32'h0000_0000, 0);
        vecs[19] = mk(0, 0, 2'b00, 32'h80,       32'h0,        32'h0,        32'h0000_0004, 0);
        vecs[20] = mk(0, 1, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 0);
        vecs[21] = mk(0, 1, 2'b10, 32'h0,        32'h20,       32'h0,        32'h0000_0004, 1);
        vecs[22] = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0000_0020, 0);

        rst = 1'b1; stall = 1'b0; sel = 2'b00; jal = '0; br = '0; jr = '0;
        rst16 = 1'b1; stall16 = 1'b0; sel16 = 2'b00; jal16 = '0; br16 = '0; jr16 = '0;

        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; stall = vecs[i].stall; sel = vecs[i].sel;
            jal = vecs[i].jal; br = vecs[i].br; jr = vecs[i].jr;
            @(posedge clk);
            #1;
            epc4 = vecs[i].e_pc + 32'd4;
            emis = (vecs[i].e_pc[1:0] != 2'b00);
            check($sformatf("v%0d PC", i),         pc,           vecs[i].e_pc);
            check($sformatf("v%0d PC_4", i),       pc4,          epc4);
            check($sformatf("v%0d pend_valid", i), {31'd0, pend}, {31'd0, vecs[i].e_pend});
            check($sformatf("v%0d misaligned", i), {31'd0, mis},  {31'd0, emis});
        end

        // Mid-stall input change must not disturb the captured target and a
        // new redirect during the same stall is dropped.
        @(negedge clk); stall = 1'b1; sel = 2'b11; jr = 32'h500;
        @(negedge clk); sel = 2'b01; jal = 32'h600; jr = 32'h700;
        @(negedge clk); stall = 1'b0; sel = 2'b10; br = 32'h900;
        @(posedge clk); #1;
        check("oldest pending PC", pc, 32'h500);
        check("oldest pending flag", {31'd0, pend}, 32'd0);

        // 16-bit instance: held in reset during the table above.
        #1;
        check("w16 reset PC", {16'd0, pc16}, 32'h1000);
        check("w16 reset PC_4", {16'd0, pc4_16}, 32'h1004);
        @(negedge clk); rst16 = 1'b0; sel16 = 2'b00;
        @(posedge clk); #1;
        check("w16 seq PC", {16'd0, pc16}, 32'h1004);
        @(negedge clk); sel16 = 2'b11; jr16 = 16'hFFFC;
        @(posedge clk); #1;
        check("w16 JR PC", {16'd0, pc16}, 32'hFFFC);
        check("w16 wrap PC_4", {16'd0, pc4_16}, 32'h0000);
        @(negedge clk); sel16 = 2'b00;
        @(posedge clk); #1;
        check("w16 wrap PC", {16'd0, pc16}, 32'h0000);
        check("w16 wrap pend", {31'd0, pend16}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
